// File: rtl/voice_arbiter.sv
// voice_arbiter: places each latched three-slot note event onto three note players, one slot
// per cycle. Build option VOICE_STEAL_EN pre-empts the oldest voice instead of dropping a slot.
module voice_arbiter #(
   parameter int unsigned NoteW = 6,
   parameter int unsigned AgeW  = 8
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               play_i,
   input  logic               beat_i,
   input  logic               new_note_i,
   input  logic [3*NoteW-1:0] notes_in_i,
   input  logic [3*NoteW-1:0] durations_in_i,
   input  logic [2:0]         voice_done_i,
   output logic               ready_o,
   output logic [2:0]         load_voice_o,
   output logic [3*NoteW-1:0] voice_note_o,
   output logic [3*NoteW-1:0] voice_duration_o,
   output logic [2:0]         busy_o,
   output logic               dropped_o
);

   localparam logic [AgeW-1:0] AgeMax = {AgeW{1'b1}};

   typedef enum logic [0:0] {StIdle, StDispatch} state_e;

   state_e                state_q, state_d;
   logic [1:0]            slot_q, slot_d;
   logic [2:1][NoteW-1:0] ev_note_q, ev_note_d;
   logic [2:1][NoteW-1:0] ev_dur_q, ev_dur_d;
   logic [2:0]            loaded_q, loaded_d;
   logic [2:0]            busy_q, busy_d;
   logic [2:0]            done_prev_q;
   logic [2:0][AgeW-1:0]  age_q, age_d;
   logic [2:0][NoteW-1:0] lane_note_q, lane_note_d;
   logic [2:0][NoteW-1:0] lane_dur_q, lane_dur_d;
   logic [2:0]            load_q, load_d;
   logic                  dropped_q, dropped_d;
   logic                  init_q;

   logic [2:0][NoteW-1:0] notes_in_v, durs_in_v;
   logic                  sel_en;
   logic [NoteW-1:0]      sel_note, sel_dur;
   logic [2:0]            cand, free, pick;
   logic [2:0]            done_rise;
`ifdef VOICE_STEAL_EN
   logic [AgeW-1:0]       best_age;
   logic                  have_best;
`endif

   assign notes_in_v = notes_in_i;
   assign durs_in_v  = durations_in_i;
   assign done_rise  = voice_done_i & ~done_prev_q;

   // The slot decided at this edge shows its load pulse in the following cycle, so slot0 is
   // taken straight from the inputs when the event is accepted.
   always_comb begin
      sel_en   = 1'b0;
      sel_note = notes_in_v[0];
      sel_dur  = durs_in_v[0];
      cand     = 3'b111;
      unique case (state_q)
         StIdle: sel_en = new_note_i;
         StDispatch: begin
            sel_en = (slot_q != 2'd2);
            cand   = ~loaded_q;
            if (slot_q == 2'd0) begin
               sel_note = ev_note_q[1];
               sel_dur  = ev_dur_q[1];
            end else begin
               sel_note = ev_note_q[2];
               sel_dur  = ev_dur_q[2];
            end
         end
         default: ;
      endcase
   end

   assign free = ~busy_q & cand;

   always_comb begin
      pick = 3'b000;
`ifdef VOICE_STEAL_EN
      best_age  = '0;
      have_best = 1'b0;
`endif
      if (free[0]) begin
         pick = 3'b001;
      end else if (free[1]) begin
         pick = 3'b010;
      end else if (free[2]) begin
         pick = 3'b100;
      end
`ifdef VOICE_STEAL_EN
      // Strict compare keeps ties on the lowest index.
      if (free == 3'b000) begin
         for (int i = 0; i < 3; i++) begin
            if (cand[i] && (!have_best || age_q[i] > best_age)) begin
               pick      = 3'b000;
               pick[i]   = 1'b1;
               best_age  = age_q[i];
               have_best = 1'b1;
            end
         end
      end
`endif
   end

   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      ev_note_d   = ev_note_q;
      ev_dur_d    = ev_dur_q;
      loaded_d    = loaded_q;
      lane_note_d = lane_note_q;
      lane_dur_d  = lane_dur_q;
      load_d      = 3'b000;
      dropped_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (new_note_i) begin
               state_d   = StDispatch;
               slot_d    = 2'd0;
               ev_note_d = notes_in_v[2:1];
               ev_dur_d  = durs_in_v[2:1];
               loaded_d  = 3'b000;
            end
         end
         StDispatch: begin
            if (slot_q == 2'd2) begin
               state_d = StIdle;
            end else begin
               slot_d = slot_q + 2'd1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (sel_en && (sel_dur != '0)) begin
         if (pick != 3'b000) begin
            load_d   = pick;
            loaded_d = loaded_d | pick;
            for (int i = 0; i < 3; i++) begin
               if (pick[i]) begin
                  lane_note_d[i] = sel_note;
                  lane_dur_d[i]  = sel_dur;
               end
            end
         end else begin
            dropped_d = 1'b1;
         end
      end
   end

   // A load in the same cycle as a done edge keeps the voice busy.
   always_comb begin
      busy_d = (busy_q & ~done_rise) | load_d;
      age_d  = age_q;
      for (int i = 0; i < 3; i++) begin
         if (load_d[i]) begin
            age_d[i] = '0;
         end else if (beat_i && busy_q[i] && (age_q[i] != AgeMax)) begin
            age_d[i] = age_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         slot_q      <= 2'd0;
         ev_note_q   <= '0;
         ev_dur_q    <= '0;
         loaded_q    <= 3'b000;
         busy_q      <= 3'b000;
         done_prev_q <= 3'b000;
         age_q       <= '0;
         lane_note_q <= '0;
         lane_dur_q  <= '0;
         load_q      <= 3'b000;
         dropped_q   <= 1'b0;
         init_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         slot_q      <= slot_d;
         ev_note_q   <= ev_note_d;
         ev_dur_q    <= ev_dur_d;
         loaded_q    <= loaded_d;
         busy_q      <= busy_d;
         done_prev_q <= voice_done_i;
         age_q       <= age_d;
         lane_note_q <= lane_note_d;
         lane_dur_q  <= lane_dur_d;
         load_q      <= load_d;
         dropped_q   <= dropped_d;
         init_q      <= 1'b1;
      end
   end

   // init_q holds ready low until the first clock after reset release.
   assign ready_o          = init_q & (state_q == StIdle) & play_i & (busy_q != 3'b111);
   assign load_voice_o     = load_q;
   assign voice_note_o     = lane_note_q;
   assign voice_duration_o = lane_dur_q;
   assign busy_o           = busy_q;
   assign dropped_o        = dropped_q;

endmodule

// File: tb/tb_voice_arbiter.sv
// tb_voice_arbiter: directed scenarios plus random traffic checked every cycle against an
// event-level reference model (voice allocation, ages, lanes, ready).
module tb_voice_arbiter;

   localparam int NoteW  = 6;
   localparam int AgeW   = 8;
   localparam int AgeMax = 255;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               play, beat, new_note;
   logic [3*NoteW-1:0] notes_in, durations_in;
   logic [2:0]         voice_done;
   logic               ready;
   logic [2:0]         load_voice;
   logic [3*NoteW-1:0] voice_note, voice_duration;
   logic [2:0]         busy;
   logic               dropped;

   always #5 clk = ~clk;

   voice_arbiter #(
      .NoteW(NoteW),
      .AgeW (AgeW)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .play_i          (play),
      .beat_i          (beat),
      .new_note_i      (new_note),
      .notes_in_i      (notes_in),
      .durations_in_i  (durations_in),
      .voice_done_i    (voice_done),
      .ready_o         (ready),
      .load_voice_o    (load_voice),
      .voice_note_o    (voice_note),
      .voice_duration_o(voice_duration),
      .busy_o          (busy),
      .dropped_o       (dropped)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: per-voice occupancy, age and lane contents, plus a queue of the
   // slots still waiting to be dispatched in the current event.
   typedef struct packed {
      logic [NoteW-1:0] note;
      logic [NoteW-1:0] dur;
   } slot_t;

   slot_t            pend_q[$];
   int               disp_left;
   int               age_m[3];
   logic [NoteW-1:0] ln_note_m[3];
   logic [NoteW-1:0] ln_dur_m[3];
   logic [2:0]       busy_m, used_m, done_prev_m, exp_load;
   logic             exp_drop, init_m;

   task automatic model_reset();
      pend_q.delete();
      disp_left   = 0;
      busy_m      = '0;
      used_m      = '0;
      done_prev_m = '0;
      exp_load    = '0;
      exp_drop    = 1'b0;
      init_m      = 1'b0;
      for (int i = 0; i < 3; i++) begin
         age_m[i]     = 0;
         ln_note_m[i] = '0;
         ln_dur_m[i]  = '0;
      end
   endtask

   task automatic model_place(input slot_t s);
      int tgt;
      tgt = -1;
      if (s.dur != 0) begin
         for (int i = 0; i < 3; i++)
            if (tgt < 0 && !busy_m[i] && !used_m[i]) tgt = i;
`ifdef VOICE_STEAL_EN
         if (tgt < 0)
            for (int i = 0; i < 3; i++)
               if (!used_m[i] && (tgt < 0 || age_m[i] > age_m[tgt])) tgt = i;
`endif
         if (tgt < 0) begin
            exp_drop = 1'b1;
         end else begin
            exp_load[tgt]  = 1'b1;
            used_m[tgt]    = 1'b1;
            ln_note_m[tgt] = s.note;
            ln_dur_m[tgt]  = s.dur;
         end
      end
   endtask

   task automatic model_edge();
      logic [2:0] rise;
      slot_t      s;
      rise     = voice_done & ~done_prev_m;
      exp_load = '0;
      exp_drop = 1'b0;
      if (disp_left == 0) begin
         if (new_note) begin
            used_m = '0;
            pend_q.delete();
            for (int k = 1; k < 3; k++) begin
               s.note = notes_in[k*NoteW +: NoteW];
               s.dur  = durations_in[k*NoteW +: NoteW];
               pend_q.push_back(s);
            end
            s.note = notes_in[0 +: NoteW];
            s.dur  = durations_in[0 +: NoteW];
            model_place(s);
            disp_left = 3;
         end
      end else begin
         if (pend_q.size() > 0) begin
            s = pend_q.pop_front();
            model_place(s);
         end
         disp_left--;
      end
      for (int i = 0; i < 3; i++) begin
         if (exp_load[i]) age_m[i] = 0;
         else if (beat && busy_m[i] && age_m[i] < AgeMax) age_m[i]++;
      end
      busy_m      = (busy_m & ~rise) | exp_load;
      done_prev_m = voice_done;
      init_m      = 1'b1;
   endtask

   function automatic logic exp_ready();
      return init_m && (disp_left == 0) && play && (busy_m != 3'b111);
   endfunction

   task automatic compare_all();
      check_eq("load_voice", 32'(load_voice), 32'(exp_load));
      check_eq("dropped", 32'(dropped), 32'(exp_drop));
      check_eq("busy", 32'(busy), 32'(busy_m));
      check_eq("ready", 32'(ready), 32'(exp_ready()));
      check_eq("voice_note", 32'(voice_note), 32'({ln_note_m[2], ln_note_m[1], ln_note_m[0]}));
      check_eq("voice_duration", 32'(voice_duration),
               32'({ln_dur_m[2], ln_dur_m[1], ln_dur_m[0]}));
      for (int i = 0; i < 3; i++) check_eq("age", 32'(dut.age_q[i]), 32'(age_m[i]));
   endtask

   task automatic step();
      @(posedge clk);
      if (rst_n) model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle(input int n);
      new_note = 1'b0;
      repeat (n) step();
   endtask

   task automatic beats(input int n);
      beat = 1'b1;
      repeat (n) step();
      beat = 1'b0;
   endtask

   task automatic send(input logic [3*NoteW-1:0] n, input logic [3*NoteW-1:0] d);
      new_note     = 1'b1;
      notes_in     = n;
      durations_in = d;
      step();
      new_note = 1'b0;
   endtask

   initial begin
      rst_n        = 1'b0;
      play         = 1'b1;
      beat         = 1'b0;
      new_note     = 1'b0;
      notes_in     = '0;
      durations_in = '0;
      voice_done   = '0;
      model_reset();
      idle(2);
      rst_n = 1'b1;
      #1 compare_all();
      idle(1);
      check_eq("ready_after_release", 32'(ready), 32'd1);

      // Reset in the middle of a dispatch aborts it.
      send({6'd3, 6'd2, 6'd1}, {6'd5, 6'd5, 6'd5});
      rst_n = 1'b0;
      model_reset();
      #1 compare_all();
      check_eq("rst_load", 32'(load_voice), 32'd0);
      idle(2);
      rst_n = 1'b1;
      #1 compare_all();
      idle(1);
      check_eq("rst_ready", 32'(ready), 32'd1);
      check_eq("rst_busy", 32'(busy), 32'd0);

      // Basic dispatch.
      send({6'd12, 6'd20, 6'd30}, {6'd4, 6'd4, 6'd4});
      check_eq("basic_load0", 32'(load_voice), 32'd1);
      idle(1);
      check_eq("basic_load1", 32'(load_voice), 32'd2);
      idle(1);
      check_eq("basic_load2", 32'(load_voice), 32'd4);
      check_eq("basic_lanes", 32'(voice_note), 32'({6'd12, 6'd20, 6'd30}));
      check_eq("basic_busy", 32'(busy), 32'd7);
      idle(1);
      check_eq("basic_ready", 32'(ready), 32'd0);

      // Done handshake frees voice1; next slot0 goes there.
      voice_done = 3'b010;
      idle(1);
      check_eq("done_busy", 32'(busy), 32'd5);
      check_eq("done_ready", 32'(ready), 32'd1);
      send({6'd0, 6'd0, 6'd7}, {6'd0, 6'd0, 6'd5});
      check_eq("done_reload", 32'(load_voice), 32'd2);
      idle(3);
      voice_done = 3'b000;
      idle(1);
      voice_done = 3'b111;
      idle(1);
      voice_done = 3'b000;
      idle(1);
      check_eq("all_free", 32'(busy), 32'd0);

      // Rest slot in the middle.
      send({6'd9, 6'd8, 6'd7}, {6'd4, 6'd0, 6'd4});
      check_eq("rest_load0", 32'(load_voice), 32'd1);
      idle(1);
      check_eq("rest_load1", 32'(load_voice), 32'd0);
      idle(1);
      check_eq("rest_load2", 32'(load_voice), 32'd2);
      check_eq("rest_lane1", 32'(voice_note[NoteW +: NoteW]), 32'd9);
      idle(1);

      // Build ages {5,9,9} with every voice busy, then offer one more valid slot.
      voice_done = 3'b111;
      idle(1);
      voice_done = 3'b000;
      idle(1);
      send({6'd1, 6'd2, 6'd3}, {6'd1, 6'd1, 6'd1});
      idle(3);
      beats(4);
      voice_done = 3'b001;
      idle(1);
      voice_done = 3'b000;
      idle(1);
      send({6'd0, 6'd0, 6'd11}, {6'd0, 6'd0, 6'd3});
      idle(3);
      beats(5);
      check_eq("age0_setup", 32'(dut.age_q[0]), 32'd5);
      check_eq("age1_setup", 32'(dut.age_q[1]), 32'd9);
      send({6'd0, 6'd21, 6'd0}, {6'd0, 6'd3, 6'd0});
      idle(1);
`ifdef VOICE_STEAL_EN
      check_eq("steal_load", 32'(load_voice), 32'd2);
      check_eq("steal_dropped", 32'(dropped), 32'd0);
      check_eq("steal_age1", 32'(dut.age_q[1]), 32'd0);
`else
      check_eq("drop_load", 32'(load_voice), 32'd0);
      check_eq("drop_pulse", 32'(dropped), 32'd1);
`endif
      idle(1);
      check_eq("drop_once", 32'(dropped), 32'd0);
      check_eq("full_busy", 32'(busy), 32'd7);
      idle(1);

      // Saturation.
      beats(300);
      for (int i = 0; i < 3; i++) check_eq("age_sat", 32'(dut.age_q[i]), 32'd255);

      // Random traffic.
      for (int c = 0; c < 2000; c++) begin
         play     = ($urandom_range(0, 7) != 0);
         beat     = ($urandom_range(0, 3) == 0);
         new_note = ($urandom_range(0, 4) == 0);
         for (int s = 0; s < 3; s++) begin
            notes_in[s*NoteW +: NoteW]     = 6'($urandom);
            durations_in[s*NoteW +: NoteW] =
               ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
         end
         for (int v = 0; v < 3; v++)
            if ($urandom_range(0, 9) == 0) voice_done[v] = ~voice_done[v];
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/voice_arbiter.md
# voice_arbiter

Dynamic voice allocator between the song reader and the three note players. It latches each three-slot note event and dispatches every valid slot, one per cycle, to a free note player. When no player is free and stealing is compiled in, it pre-empts the oldest voice. It replaces the fixed slot-to-player wiring and the AND-of-done gating with a single `ready` handshake back to the song reader.

## Interface
- `NOTE_W`, 6, width of one note code and one duration field
- `AGE_W`, 8, width of each per-voice age counter (beats since load)

- `clk` in 1: system clock
- `reset` in 1: asynchronous, active-low reset
- `play` in 1: playback enable from the MCU
- `beat` in 1: one-cycle beat pulse from the beat generator
- `new_note` in 1: one-cycle pulse; `notes_in`/`durations_in` valid
- `notes_in` in 3*NOTE_W: slot2..slot0 notes, slot0 in the LSBs
- `durations_in` in 3*NOTE_W: slot2..slot0 durations, slot0 in the LSBs
- `voice_done` in 3: per-player `done_with_note` level, bit i = player i
- `ready` out 1: arbiter can accept a `new_note`; drives song reader `note_done`
- `load_voice` out 3: one-cycle load pulse per player
- `voice_note` out 3*NOTE_W: per-player note lanes, held between loads
- `voice_duration` out 3*NOTE_W: per-player duration lanes, held between loads
- `busy` out 3: per-player occupancy
- `dropped` out 1: one-cycle pulse when a slot could not be placed

## Operation
- **States:** IDLE, DISPATCH, and no others. The slot index `s` is a 2-bit counter, 0..2.
- **IDLE:**
  - `ready = play & (|~busy)`.
  - On `new_note`, latch all slots, set s=0, and go to DISPATCH. `new_note` is honoured in IDLE even when `ready`=0.
  - `new_note` in DISPATCH is ignored.
- **DISPATCH:** handles one slot per cycle.
  - A slot is valid iff its duration != 0. An invalid slot produces no load.
  - Target voice: the lowest-index voice with `busy`=0 that has not already been loaded in this event.
  - If there is no free voice, stealing selects the voice with the maximum age; ties go to the lowest index.
  - On placement: pulse `load_voice[i]`, write lane i, set `busy[i]`, clear `age[i]`.
  - After s=2, return to IDLE.
- **Busy clear:** `busy[i]` clears on a rising edge of `voice_done[i]` (previous-cycle register). A load in the same cycle wins.
- **Age:** `age[i]` increments on `beat` while `busy[i]` is set, and saturates at 2^AGE_W-1.
- **`play` low:** gates `ready` only. A dispatch in progress completes. Ages still count on `beat`.
- **Reset values:** state=IDLE; `busy`, `load_voice`, `dropped`, lanes, and ages all 0; `ready`=0 until the first clock after reset release.

## Timing
- All outputs are registered. `ready` is combinational from state/`busy`/`play` only, never from `new_note`.
- `new_note` in cycle N:
  - slot0 load pulse in N+1
  - slot1 load pulse in N+2
  - slot2 load pulse in N+3
  - IDLE in N+4, with `ready` re-evaluated in N+4
- Lane data is valid in the same cycle as its `load_voice` pulse and is held afterwards.
- A voice never receives two loads in one event.
- Reset assertion mid-dispatch aborts immediately. No further load pulses are issued.

## Configuration
- `VOICE_STEAL_EN` defined:
  - An unplaceable valid slot steals the oldest voice.
  - The stolen voice's lane is overwritten, it gets a load pulse, and its age is reset.
  - `dropped` is never asserted.
- `VOICE_STEAL_EN` undefined:
  - An unplaceable valid slot is discarded.
  - `dropped` pulses in that slot's dispatch cycle.
  - No load pulse is issued for that slot.

## Test plan
- **Reset:** hold `reset`=0 mid-dispatch, then release. Required: all outputs 0; IDLE; `ready`=1 the cycle after release with `play`=1.
- **Basic dispatch:** all voices idle; `new_note` with notes {12,20,30}, durations {4,4,4}. Required: loads 001, 010, 100 in N+1..N+3; lane0=30, lane1=20, lane2=12; `busy`=111; `ready`=0.
- **Rest slot:** slot1 duration 0. Required: no pulse in N+2; slot2 loads voice1.
- **Done handshake:** after the basic dispatch, raise `voice_done[1]`. Required: `busy[1]`=0 next cycle; `ready`=1; the next event's slot0 goes to voice1.
- **Stealing (with `VOICE_STEAL_EN`):** all busy, ages {5,9,9}; force an event with one valid slot. Required: load 010, age1=0, `dropped`=0.
- **Dropping (without `VOICE_STEAL_EN`):** same as the stealing scenario. Required: no load, `dropped` pulses once, `busy` unchanged.
- **Age saturation:** 300 beats on a busy voice with AGE_W=8. Required: age=255.
